// File: rtl/decode_dispatch_queue_if.sv
// Decode->ROB dual-lane request bundle: decoder enqueue side, global controls and backend dispatch side.
// The queue takes the slave view; the decoder/backend environment takes the master view.
interface decode_dispatch_queue_if #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             global_wfi_i;
  logic             global_trap_i;
  logic             global_ret_i;
  logic             enq_valid_first_i;
  logic             enq_valid_second_i;
  logic [UOP_W-1:0] enq_uop_first_i;
  logic [UOP_W-1:0] enq_uop_second_i;
  logic             enq_ready_first_o;
  logic             enq_ready_second_o;
  logic             deco_rob_req_valid_first_o;
  logic             deco_rob_req_valid_second_o;
  logic             deco_rob_req_ready_first_i;
  logic             deco_rob_req_ready_second_i;
  logic [UOP_W-1:0] deco_uop_first_o;
  logic [UOP_W-1:0] deco_uop_second_o;
  logic [CW-1:0]    count_o;

  modport slave (
    input  global_wfi_i, global_trap_i, global_ret_i,
    input  enq_valid_first_i, enq_valid_second_i, enq_uop_first_i, enq_uop_second_i,
    output enq_ready_first_o, enq_ready_second_o,
    output deco_rob_req_valid_first_o, deco_rob_req_valid_second_o,
    input  deco_rob_req_ready_first_i, deco_rob_req_ready_second_i,
    output deco_uop_first_o, deco_uop_second_o, count_o
  );

  modport master (
    output global_wfi_i, global_trap_i, global_ret_i,
    output enq_valid_first_i, enq_valid_second_i, enq_uop_first_i, enq_uop_second_i,
    input  enq_ready_first_o, enq_ready_second_o,
    input  deco_rob_req_valid_first_o, deco_rob_req_valid_second_o,
    output deco_rob_req_ready_first_i, deco_rob_req_ready_second_i,
    input  deco_uop_first_o, deco_uop_second_o, count_o
  );
endinterface

// File: rtl/decode_dispatch_queue.sv
// Dual-lane in-order decode dispatch queue: circular buffer feeding the ROB up to two uops per cycle.
// Readies come from the registered count only, so a dequeue never grants same-cycle enqueue credit.
module decode_dispatch_queue #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 256
) (
  input logic                  clk,
  input logic                  rst,
  decode_dispatch_queue_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic flush, fire0, fire1, deq0, deq1;
  logic [1:0] n_enq, n_deq;
  logic [AW-1:0] head_p1, tail_p1;

  assign flush   = io.global_trap_i | io.global_ret_i;
  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  assign io.enq_ready_first_o  = (count < FULL) & ~flush;
  assign io.enq_ready_second_o = (count < FULL - CW'(1)) & ~flush;

  assign io.deco_rob_req_valid_first_o  = (count != '0) & ~io.global_wfi_i & ~flush;
  assign io.deco_rob_req_valid_second_o = (count > CW'(1)) & ~io.global_wfi_i & ~flush;

  assign fire0 = io.enq_valid_first_i & io.enq_ready_first_o;
  assign fire1 = fire0 & io.enq_valid_second_i & io.enq_ready_second_o;
  assign deq0  = io.deco_rob_req_valid_first_o & io.deco_rob_req_ready_first_i;
  assign deq1  = deq0 & io.deco_rob_req_valid_second_o & io.deco_rob_req_ready_second_i;

  assign n_enq = {1'b0, fire0} + {1'b0, fire1};
  assign n_deq = {1'b0, deq0} + {1'b0, deq1};

  assign io.deco_uop_first_o  = mem[head];
  assign io.deco_uop_second_o = mem[head_p1];
  assign io.count_o           = count;

  // Payload storage is deliberately left unreset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (fire0) mem[tail]    <= io.enq_uop_first_i;
    if (fire1) mem[tail_p1] <= io.enq_uop_second_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_deq);
      tail  <= tail + AW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_deq);
    end
  end
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Bench for decode_dispatch_queue: queue-based reference model checked every cycle, plus directed literal checks.
// Dispatch order is also logged from the DUT outputs and compared against the enqueued tag sequence.
module tb_decode_dispatch_queue;
  localparam int DEPTH = 8;
  localparam int UOP_W = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_dispatch_queue_if #(.DEPTH(DEPTH), .UOP_W(UOP_W)) bus ();

  decode_dispatch_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [UOP_W-1:0] mdl_q[$];
  logic [UOP_W-1:0] out_log[$];
  int               pend_enq, pend_deq;
  logic             pend_flush;
  logic [UOP_W-1:0] pend_u0, pend_u1;

  function automatic logic [UOP_W-1:0] mk(input int t);
    logic [31:0] w;
    w = 32'(t) + 32'hC0DE_0000;
    return {8{w}};
  endfunction

  task automatic check(input string name, input logic [UOP_W-1:0] act, input logic [UOP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  // Reference: outputs derived from the occupancy of an ordered list of pending uops.
  always @(negedge clk) begin
    bit flush, wfi, f0, f1, d0, d1, vf, vs;
    int sz;
    if (rst) begin
      sz    = mdl_q.size();
      flush = bus.global_trap_i | bus.global_ret_i;
      wfi   = bus.global_wfi_i;
      vf    = sz >= 1 && !wfi && !flush;
      vs    = sz >= 2 && !wfi && !flush;
      check("m_count", UOP_W'(bus.count_o), UOP_W'(sz));
      check("m_rdy0", UOP_W'(bus.enq_ready_first_o), UOP_W'(!flush && sz < DEPTH));
      check("m_rdy1", UOP_W'(bus.enq_ready_second_o), UOP_W'(!flush && sz <= DEPTH - 2));
      check("m_vf", UOP_W'(bus.deco_rob_req_valid_first_o), UOP_W'(vf));
      check("m_vs", UOP_W'(bus.deco_rob_req_valid_second_o), UOP_W'(vs));
      if (vf) check("m_uop0", bus.deco_uop_first_o, mdl_q[0]);
      if (vs) check("m_uop1", bus.deco_uop_second_o, mdl_q[1]);
      f0 = bus.enq_valid_first_i && !flush && sz < DEPTH;
      f1 = f0 && bus.enq_valid_second_i && sz <= DEPTH - 2;
      d0 = vf && bus.deco_rob_req_ready_first_i;
      d1 = d0 && vs && bus.deco_rob_req_ready_second_i;
      if (d0) out_log.push_back(bus.deco_uop_first_o);
      if (d1) out_log.push_back(bus.deco_uop_second_o);
      pend_flush = flush;
      pend_enq   = int'(f0) + int'(f1);
      pend_deq   = int'(d0) + int'(d1);
      pend_u0    = bus.enq_uop_first_i;
      pend_u1    = bus.enq_uop_second_i;
    end else begin
      pend_flush = 1'b0;
      pend_enq   = 0;
      pend_deq   = 0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_q.delete();
    end else if (pend_flush) begin
      mdl_q.delete();
    end else begin
      for (int k = 0; k < pend_deq; k++) void'(mdl_q.pop_front());
      if (pend_enq >= 1) mdl_q.push_back(pend_u0);
      if (pend_enq == 2) mdl_q.push_back(pend_u1);
    end
  end

  task automatic drive(input bit e0, input bit e1, input int t0, input int t1,
                       input bit r0, input bit r1, input bit wfi, input bit trap);
    bus.enq_valid_first_i           = e0;
    bus.enq_valid_second_i          = e1;
    bus.enq_uop_first_i             = mk(t0);
    bus.enq_uop_second_i            = mk(t1);
    bus.deco_rob_req_ready_first_i  = r0;
    bus.deco_rob_req_ready_second_i = r1;
    bus.global_wfi_i                = wfi;
    bus.global_trap_i               = trap;
    bus.global_ret_i                = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && bus.count_o != 0; k++) begin
      drive(0, 0, 0, 0, 1, 1, 0, 0);
      tick();
    end
    check("drain_empty", UOP_W'(bus.count_o), '0);
  endtask

  initial begin
    int tag, lsz;
    bit e0, e1, done;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12 rst = 1'b1;
    tick();

    // 1: reset state, dual enqueue, dual dispatch
    drive(1, 1, 100, 101, 0, 0, 0, 0);
    check("rst_count", UOP_W'(bus.count_o), '0);
    check("rst_vf", UOP_W'(bus.deco_rob_req_valid_first_o), '0);
    check("rst_rdy0", UOP_W'(bus.enq_ready_first_o), UOP_W'(1));
    check("rst_rdy1", UOP_W'(bus.enq_ready_second_o), UOP_W'(1));
    tick();
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    check("t1_vf", UOP_W'(bus.deco_rob_req_valid_first_o), UOP_W'(1));
    check("t1_uop0", bus.deco_uop_first_o, mk(100));
    check("t1_vs", UOP_W'(bus.deco_rob_req_valid_second_o), UOP_W'(1));
    check("t1_uop1", bus.deco_uop_second_o, mk(101));
    tick();
    check("t1_count", UOP_W'(bus.count_o), '0);

    // 2: partial accept
    drive(1, 1, 200, 201, 0, 0, 0, 0); tick();
    drive(1, 0, 202, 0, 0, 0, 0, 0);   tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0);     tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_uop0", bus.deco_uop_first_o, mk(201));
    check("t2_uop1", bus.deco_uop_second_o, mk(202));
    check("t2_count", UOP_W'(bus.count_o), UOP_W'(2));
    drain();

    // 3: fill to full, refused enqueue while dequeuing two at full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 300 + i, 0, 0, 0, 0, 0);
      if (i == DEPTH - 1) begin
        check("t3_c7_rdy0", UOP_W'(bus.enq_ready_first_o), UOP_W'(1));
        check("t3_c7_rdy1", UOP_W'(bus.enq_ready_second_o), '0);
      end
      tick();
    end
    drive(1, 1, 390, 391, 1, 1, 0, 0);
    check("t3_full_count", UOP_W'(bus.count_o), UOP_W'(8));
    check("t3_full_rdy0", UOP_W'(bus.enq_ready_first_o), '0);
    check("t3_full_rdy1", UOP_W'(bus.enq_ready_second_o), '0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_after_count", UOP_W'(bus.count_o), UOP_W'(6));
    check("t3_after_uop0", bus.deco_uop_first_o, mk(302));
    drain();

    // 4: wrap with random lane usage and backend readiness
    out_log.delete();
    tag  = 0;
    done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (tag == 20 && bus.count_o == 0) begin
        done = 1;
      end else begin
        e0 = tag < 20 && ($urandom % 4 != 0);
        e1 = e0 && tag + 1 < 20 && ($urandom % 2 == 1);
        drive(e0, e1, tag, tag + 1, $urandom % 4 != 0, $urandom % 2 == 1, 0, 0);
        if (e0 && bus.enq_ready_first_o) begin
          tag++;
          if (e1 && bus.enq_ready_second_o) tag++;
        end
        tick();
      end
    end
    check("t4_done", UOP_W'(done), UOP_W'(1));
    check("t4_len", UOP_W'(out_log.size()), UOP_W'(20));
    for (int i = 0; i < 20 && i < out_log.size(); i++) check("t4_order", out_log[i], mk(i));

    // 5: trap flush at count 5 with traffic on both sides
    drive(1, 1, 500, 501, 0, 0, 0, 0); tick();
    drive(1, 1, 502, 503, 0, 0, 0, 0); tick();
    drive(1, 0, 504, 0, 0, 0, 0, 0);   tick();
    lsz = out_log.size();
    drive(1, 1, 505, 506, 1, 1, 0, 1);
    check("t5_pre_count", UOP_W'(bus.count_o), UOP_W'(5));
    check("t5_vf", UOP_W'(bus.deco_rob_req_valid_first_o), '0);
    check("t5_vs", UOP_W'(bus.deco_rob_req_valid_second_o), '0);
    check("t5_rdy0", UOP_W'(bus.enq_ready_first_o), '0);
    check("t5_rdy1", UOP_W'(bus.enq_ready_second_o), '0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    check("t5_count", UOP_W'(bus.count_o), '0);
    check("t5_no_disp", UOP_W'(out_log.size()), UOP_W'(lsz));
    tick();

    // 6: wfi hold, release, then async reset mid-cycle
    drive(1, 1, 600, 601, 0, 0, 0, 0); tick();
    drive(1, 0, 602, 0, 0, 0, 0, 0);   tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 1, 1, 0);
      check("t6_wfi_vf", UOP_W'(bus.deco_rob_req_valid_first_o), '0);
      check("t6_wfi_count", UOP_W'(bus.count_o), UOP_W'(3));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_rel_vf", UOP_W'(bus.deco_rob_req_valid_first_o), UOP_W'(1));
    check("t6_rel_uop0", bus.deco_uop_first_o, mk(600));
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    check("t6_pre_rst_count", UOP_W'(bus.count_o), UOP_W'(2));
    #2 rst = 1'b0;
    #1;
    check("t6_rst_count", UOP_W'(bus.count_o), '0);
    check("t6_rst_vf", UOP_W'(bus.deco_rob_req_valid_first_o), '0);
    check("t6_rst_rdy1", UOP_W'(bus.enq_ready_second_o), UOP_W'(1));
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
